// File: rtl/id_exe_pipe.sv
// ID decode, EXE ALU and the ID/EXE + EXE/MEM register slices of the 5-stage MIPS core.
// Both register slices reset to an all-zero bubble and hold together while frozen.
module id_exe_pipe (
    input  logic        clk,
    input  logic        rst_b,
    input  logic        freeze,
    input  logic [31:0] inst_id,
    input  logic [31:0] pc_id,
    input  logic [31:0] rs_data,
    input  logic [31:0] rt_data,
    output logic [4:0]  reg1_num,
    output logic [4:0]  reg2_num,
    output logic [1:0]  reg_valid,
    output logic        is_sw_sb_id,
    output logic [31:0] imm_ext,
    output logic [31:0] rs_val_id,
    output logic        zero,
    output logic [2:0]  branch_id,
    output logic [1:0]  jump_id,
    output logic        jr_id,
    output logic [31:0] alu_result_exe,
    output logic [4:0]  dest_reg_num_exe,
    output logic        reg_write_exe,
    output logic [31:0] alu_result_mem,
    output logic [31:0] store_data_mem,
    output logic [31:0] pc_mem,
    output logic [4:0]  dest_reg_num_mem,
    output logic [1:0]  jump_mem,
    output logic [6:0]  ctrl_mem
);
    localparam logic [3:0] ALU_ADD = 4'd0, ALU_SUB = 4'd1, ALU_AND = 4'd2, ALU_OR = 4'd3,
                           ALU_XOR = 4'd4, ALU_NOR = 4'd5, ALU_SLT = 4'd6, ALU_SLTU = 4'd7,
                           ALU_SLL = 4'd8, ALU_SRL = 4'd9, ALU_SRA = 4'd10, ALU_LUI = 4'd11;

    logic [5:0]  w_op, w_funct;
    logic [4:0]  w_rd, w_shamt;
    logic [31:0] w_imm_zext, w_val1, w_val2;
    logic [3:0]  w_alu_op;
    logic [4:0]  w_dest;
    logic        w_wr, w_halt, w_m2r, w_cache, w_sw_sb, w_lb_sb, w_memw, w_rs_used, w_rt_used;
    logic [6:0]  w_ctrl;

    assign w_op       = inst_id[31:26];
    assign w_funct    = inst_id[5:0];
    assign w_rd       = inst_id[15:11];
    assign w_shamt    = inst_id[10:6];
    assign reg1_num   = inst_id[25:21];
    assign reg2_num   = inst_id[20:16];
    assign imm_ext    = {{16{inst_id[15]}}, inst_id[15:0]};
    assign w_imm_zext = {16'h0000, inst_id[15:0]};
    assign rs_val_id  = rs_data;

    // Instruction decode: operands, ALU op, destination and control bits
    always_comb begin
        w_alu_op = ALU_ADD;
        w_val1 = 32'h0;
        w_val2 = 32'h0;
        w_dest = 5'd0;
        w_wr = 1'b0;
        w_halt = 1'b0;
        w_m2r = 1'b0;
        w_cache = 1'b0;
        w_sw_sb = 1'b0;
        w_lb_sb = 1'b0;
        w_memw = 1'b0;
        w_rs_used = 1'b0;
        w_rt_used = 1'b0;
        branch_id = 3'd0;
        jump_id = 2'd0;
        jr_id = 1'b0;
        case (w_op)
            6'h00: begin
                w_val1 = rs_data;
                w_val2 = rt_data;
                w_dest = w_rd;
                w_wr = 1'b1;
                w_rs_used = 1'b1;
                w_rt_used = 1'b1;
                case (w_funct)
                    6'h20, 6'h21: w_alu_op = ALU_ADD;
                    6'h22, 6'h23: w_alu_op = ALU_SUB;
                    6'h24: w_alu_op = ALU_AND;
                    6'h25: w_alu_op = ALU_OR;
                    6'h26: w_alu_op = ALU_XOR;
                    6'h27: w_alu_op = ALU_NOR;
                    6'h2A: w_alu_op = ALU_SLT;
                    6'h2B: w_alu_op = ALU_SLTU;
                    6'h00, 6'h02, 6'h03: begin
                        w_alu_op = (w_funct == 6'h00) ? ALU_SLL :
                                   (w_funct == 6'h02) ? ALU_SRL : ALU_SRA;
                        w_val1 = {27'h0, w_shamt};
                        w_rs_used = 1'b0;
                    end
                    6'h04: w_alu_op = ALU_SLL;
                    6'h06: w_alu_op = ALU_SRL;
                    6'h07: w_alu_op = ALU_SRA;
                    6'h08: begin
                        jr_id = 1'b1;
                        w_wr = 1'b0;
                        w_dest = 5'd0;
                        w_rt_used = 1'b0;
                    end
                    6'h09: begin
                        jr_id = 1'b1;
                        jump_id = 2'd2;
                        w_rt_used = 1'b0;
                    end
                    6'h0C: begin
                        w_halt = 1'b1;
                        w_wr = 1'b0;
                        w_dest = 5'd0;
                        w_rs_used = 1'b0;
                        w_rt_used = 1'b0;
                    end
                    default: begin
                        w_wr = 1'b0;
                        w_dest = 5'd0;
                        w_rs_used = 1'b0;
                        w_rt_used = 1'b0;
                    end
                endcase
            end
            6'h08, 6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0D, 6'h0E, 6'h0F: begin
                w_val1 = rs_data;
                w_val2 = imm_ext;
                w_dest = reg2_num;
                w_wr = 1'b1;
                w_rs_used = 1'b1;
                case (w_op)
                    6'h0A: w_alu_op = ALU_SLT;
                    6'h0B: w_alu_op = ALU_SLTU;
                    6'h0C: begin w_alu_op = ALU_AND; w_val2 = w_imm_zext; end
                    6'h0D: begin w_alu_op = ALU_OR;  w_val2 = w_imm_zext; end
                    6'h0E: begin w_alu_op = ALU_XOR; w_val2 = w_imm_zext; end
                    6'h0F: begin w_alu_op = ALU_LUI; w_rs_used = 1'b0; end
                    default: w_alu_op = ALU_ADD;
                endcase
            end
            6'h20, 6'h23: begin
                w_val1 = rs_data;
                w_val2 = imm_ext;
                w_dest = reg2_num;
                w_wr = 1'b1;
                w_m2r = 1'b1;
                w_cache = 1'b1;
                w_lb_sb = (w_op == 6'h20);
                w_rs_used = 1'b1;
            end
            6'h28, 6'h2B: begin
                w_val1 = rs_data;
                w_val2 = imm_ext;
                w_cache = 1'b1;
                w_memw = 1'b1;
                w_sw_sb = 1'b1;
                w_lb_sb = (w_op == 6'h28);
                w_rs_used = 1'b1;
                w_rt_used = 1'b1;
            end
            6'h04, 6'h05, 6'h06, 6'h07: begin
                branch_id = 3'(w_op - 6'h03);
                w_rs_used = 1'b1;
                w_rt_used = (w_op == 6'h04) || (w_op == 6'h05);
            end
            6'h01: begin
                if (reg2_num == 5'd0 || reg2_num == 5'd1) begin
                    branch_id = (reg2_num == 5'd0) ? 3'd5 : 3'd6;
                    w_rs_used = 1'b1;
                end
            end
            6'h02: jump_id = 2'd1;
            6'h03: begin
                jump_id = 2'd2;
                w_dest = 5'd31;
                w_wr = 1'b1;
            end
            default: ;
        endcase
    end

    assign reg_valid   = {w_rt_used, w_rs_used};
    assign is_sw_sb_id = w_sw_sb;
    assign w_ctrl = {w_halt, w_wr & (w_dest != 5'd0), w_m2r, w_cache, w_sw_sb, w_lb_sb, w_memw};

    // Branch condition, signed comparisons on the forwarded operands
    always_comb begin
        case (branch_id)
            3'd1:    zero = (rs_data == rt_data);
            3'd2:    zero = (rs_data != rt_data);
            3'd3:    zero = ($signed(rs_data) <= 32'sd0);
            3'd4:    zero = ($signed(rs_data) >  32'sd0);
            3'd5:    zero = ($signed(rs_data) <  32'sd0);
            3'd6:    zero = ($signed(rs_data) >= 32'sd0);
            default: zero = 1'b0;
        endcase
    end

    logic [31:0] r_val1, r_val2, r_store_exe, r_pc_exe;
    logic [3:0]  r_alu_op;
    logic [4:0]  r_dest_exe;
    logic [6:0]  r_ctrl_exe;
    logic [1:0]  r_jump_exe;

    // ID/EXE and EXE/MEM slices; reset yields a bubble, freeze holds both
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            r_val1 <= '0; r_val2 <= '0; r_store_exe <= '0; r_pc_exe <= '0;
            r_alu_op <= '0; r_dest_exe <= '0; r_ctrl_exe <= '0; r_jump_exe <= '0;
            alu_result_mem <= '0; store_data_mem <= '0; pc_mem <= '0;
            dest_reg_num_mem <= '0; jump_mem <= '0; ctrl_mem <= '0;
        end else if (!freeze) begin
            r_val1 <= w_val1; r_val2 <= w_val2; r_store_exe <= rt_data; r_pc_exe <= pc_id;
            r_alu_op <= w_alu_op; r_dest_exe <= w_dest; r_ctrl_exe <= w_ctrl; r_jump_exe <= jump_id;
            alu_result_mem <= alu_result_exe; store_data_mem <= r_store_exe; pc_mem <= r_pc_exe;
            dest_reg_num_mem <= r_dest_exe; jump_mem <= r_jump_exe; ctrl_mem <= r_ctrl_exe;
        end
    end

    assign dest_reg_num_exe = r_dest_exe;
    assign reg_write_exe    = r_ctrl_exe[5];

    always_comb begin
        case (r_alu_op)
            ALU_ADD:  alu_result_exe = r_val1 + r_val2;
            ALU_SUB:  alu_result_exe = r_val1 - r_val2;
            ALU_AND:  alu_result_exe = r_val1 & r_val2;
            ALU_OR:   alu_result_exe = r_val1 | r_val2;
            ALU_XOR:  alu_result_exe = r_val1 ^ r_val2;
            ALU_NOR:  alu_result_exe = ~(r_val1 | r_val2);
            ALU_SLT:  alu_result_exe = {31'h0, $signed(r_val1) < $signed(r_val2)};
            ALU_SLTU: alu_result_exe = {31'h0, r_val1 < r_val2};
            ALU_SLL:  alu_result_exe = r_val2 << r_val1[4:0];
            ALU_SRL:  alu_result_exe = r_val2 >> r_val1[4:0];
            ALU_SRA:  alu_result_exe = 32'($signed(r_val2) >>> r_val1[4:0]);
            ALU_LUI:  alu_result_exe = r_val2 << 16;
            default:  alu_result_exe = 32'h0;
        endcase
    end
endmodule

// File: tb/tb_id_exe_pipe.sv
// Directed self-checking bench for id_exe_pipe with hand-computed expectations.
module tb_id_exe_pipe;
    logic        clk = 1'b0;
    logic        rst_b, freeze;
    logic [31:0] inst_id, pc_id, rs_data, rt_data;
    logic [4:0]  reg1_num, reg2_num, dest_reg_num_exe, dest_reg_num_mem;
    logic [1:0]  reg_valid, jump_id, jump_mem;
    logic        is_sw_sb_id, zero, jr_id, reg_write_exe;
    logic [31:0] imm_ext, rs_val_id, alu_result_exe, alu_result_mem, store_data_mem, pc_mem;
    logic [2:0]  branch_id;
    logic [6:0]  ctrl_mem;

    int n_checks = 0;
    int n_errors = 0;

    id_exe_pipe dut (
        .clk(clk), .rst_b(rst_b), .freeze(freeze), .inst_id(inst_id), .pc_id(pc_id),
        .rs_data(rs_data), .rt_data(rt_data), .reg1_num(reg1_num), .reg2_num(reg2_num),
        .reg_valid(reg_valid), .is_sw_sb_id(is_sw_sb_id), .imm_ext(imm_ext),
        .rs_val_id(rs_val_id), .zero(zero), .branch_id(branch_id), .jump_id(jump_id),
        .jr_id(jr_id), .alu_result_exe(alu_result_exe), .dest_reg_num_exe(dest_reg_num_exe),
        .reg_write_exe(reg_write_exe), .alu_result_mem(alu_result_mem),
        .store_data_mem(store_data_mem), .pc_mem(pc_mem), .dest_reg_num_mem(dest_reg_num_mem),
        .jump_mem(jump_mem), .ctrl_mem(ctrl_mem)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [31:0] inst, input logic [31:0] rs, input logic [31:0] rt);
        inst_id = inst;
        rs_data = rs;
        rt_data = rt;
        #1;
    endtask

    initial begin
        rst_b = 1'b0; freeze = 1'b0; pc_id = 32'h0;
        drive(32'h0, 32'h0, 32'h0);
        repeat (2) tick();
        chk("rst_ctrl_mem", 32'(ctrl_mem), 32'h0);
        chk("rst_alu_mem", alu_result_mem, 32'h0);
        rst_b = 1'b1;
        repeat (2) tick();
        chk("nop_ctrl_mem", 32'(ctrl_mem), 32'h0);
        chk("nop_alu_mem", alu_result_mem, 32'h0);
        chk("nop_rw_exe", 32'(reg_write_exe), 32'h0);

        // ADDI $5,$0,-3
        drive(32'h2005FFFD, 32'h0, 32'h0);
        chk("addi_imm", imm_ext, 32'hFFFFFFFD);
        chk("addi_r2", 32'(reg2_num), 32'd5);
        tick();
        chk("addi_exe", alu_result_exe, 32'hFFFFFFFD);
        chk("addi_rw_exe", 32'(reg_write_exe), 32'h1);
        drive(32'h0, 32'h0, 32'h0);
        tick();
        chk("addi_mem", alu_result_mem, 32'hFFFFFFFD);
        chk("addi_dest", 32'(dest_reg_num_mem), 32'd5);
        chk("addi_ctrl", 32'(ctrl_mem), 32'h20);

        // SW $7,8($4)
        drive(32'hAC870008, 32'd100, 32'hAB);
        chk("sw_id", 32'(is_sw_sb_id), 32'h1);
        chk("sw_rv", 32'(reg_valid), 32'h3);
        tick();
        drive(32'h0, 32'h0, 32'h0);
        tick();
        chk("sw_addr", alu_result_mem, 32'd108);
        chk("sw_data", store_data_mem, 32'hAB);
        chk("sw_ctrl", 32'(ctrl_mem), 32'h0D);

        // Branch resolution in ID
        drive(32'h10220004, 32'd9, 32'd9);
        chk("beq_zero", 32'(zero), 32'h1);
        chk("beq_code", 32'(branch_id), 32'd1);
        drive(32'h14220004, 32'd9, 32'd9);
        chk("bne_zero", 32'(zero), 32'h0);
        chk("bne_code", 32'(branch_id), 32'd2);
        drive(32'h18200004, 32'd0, 32'd0);
        chk("blez_zero", 32'(zero), 32'h1);
        drive(32'h04210004, 32'hFFFFFFFF, 32'd0);
        chk("bgez_zero", 32'(zero), 32'h0);
        chk("bgez_code", 32'(branch_id), 32'd6);
        chk("bgez_rv", 32'(reg_valid), 32'h1);

        // ALU corner cases
        drive(32'h0022182A, 32'hFFFFFFFF, 32'd1);
        tick();
        chk("slt", alu_result_exe, 32'd1);
        drive(32'h0022182B, 32'hFFFFFFFF, 32'd1);
        tick();
        chk("sltu", alu_result_exe, 32'd0);
        drive(32'h00021903, 32'h0, 32'h80000000);
        tick();
        chk("sra", alu_result_exe, 32'hF8000000);
        drive(32'h34248000, 32'd1, 32'h0);
        tick();
        chk("ori_zext", alu_result_exe, 32'h00008001);
        drive(32'h3C061234, 32'h0, 32'h0);
        tick();
        chk("lui", alu_result_exe, 32'h12340000);
        drive(32'h20200005, 32'd1, 32'h0);
        tick();
        chk("wr_r0", 32'(reg_write_exe), 32'h0);
        chk("wr_r0_val", alu_result_exe, 32'd6);

        // LW stream with a three-cycle freeze
        drive(32'h8C280000, 32'h10, 32'h0);
        tick();
        drive(32'h8C280000, 32'h20, 32'h0);
        tick();
        chk("lw_a_mem", alu_result_mem, 32'h10);
        chk("lw_ctrl", 32'(ctrl_mem), 32'h38);
        chk("lw_dest", 32'(dest_reg_num_mem), 32'd8);
        freeze = 1'b1;
        drive(32'h8C280000, 32'h30, 32'h0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("frz_mem", alu_result_mem, 32'h10);
            chk("frz_exe", alu_result_exe, 32'h20);
        end
        chk("frz_comb", rs_val_id, 32'h30);
        freeze = 1'b0;
        tick();
        chk("unfrz_b", alu_result_mem, 32'h20);
        drive(32'h8C280000, 32'h40, 32'h0);
        tick();
        chk("unfrz_c", alu_result_mem, 32'h30);

        // SYSCALL halts
        drive(32'h0000000C, 32'h0, 32'h0);
        tick();
        drive(32'h0, 32'h0, 32'h0);
        tick();
        chk("syscall", 32'(ctrl_mem), 32'h40);

        // JAL links through $31 and carries its PC
        pc_id = 32'h400;
        drive(32'h0C000010, 32'h0, 32'h0);
        chk("jal_jump_id", 32'(jump_id), 32'd2);
        tick();
        pc_id = 32'h0;
        drive(32'h0, 32'h0, 32'h0);
        tick();
        chk("jal_jump_mem", 32'(jump_mem), 32'd2);
        chk("jal_dest", 32'(dest_reg_num_mem), 32'd31);
        chk("jal_pc", pc_mem, 32'h400);
        chk("jal_ctrl", 32'(ctrl_mem), 32'h20);

        // JALR decode
        drive(32'h0020F809, 32'h123, 32'h0);
        chk("jalr_jr", 32'(jr_id), 32'h1);
        chk("jalr_jump", 32'(jump_id), 32'd2);

        // Asynchronous reset mid-stream
        drive(32'h2005FFFD, 32'h0, 32'h0);
        tick();
        tick();
        #2;
        rst_b = 1'b0;
        #1;
        chk("areset_mem", alu_result_mem, 32'h0);
        chk("areset_ctrl", 32'(ctrl_mem), 32'h0);
        chk("areset_exe", alu_result_exe, 32'h0);
        chk("areset_rw", 32'(reg_write_exe), 32'h0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/id_exe_pipe.md
Name: id_exe_pipe

Overview:
- Decode, execute and EXE→MEM register slice of the 5-stage MIPS core.
- Combinationally decodes the ID-stage instruction: register numbers, operands, branch/jump resolution, control bits.
- Registers the decoded bundle into an internal ID/EXE register and computes the ALU result.
- Registers the result and control bits into the EXE/MEM register feeding the memory stage.

Parameters:
none

Ports:
clk  in  1  clock, rising edge
rst_b  in  1  asynchronous active-low reset
freeze  in  1  memory stall; both internal pipeline registers hold
inst_id  in  32  instruction in ID
pc_id  in  32  PC of instruction in ID
rs_data  in  32  forwarded value of reg1_num
rt_data  in  32  forwarded value of reg2_num
reg1_num  out  5  rs field (inst[25:21])
reg2_num  out  5  rt field (inst[20:16])
reg_valid  out  2  {rt used, rs used} for hazard detection
is_sw_sb_id  out  1  ID instruction is SW/SB (rt read as store data)
imm_ext  out  32  sign-extended inst[15:0]
rs_val_id  out  32  rs_data passthrough (JR target)
zero  out  1  branch condition true
branch_id  out  3  0 none, 1 BEQ, 2 BNE, 3 BLEZ, 4 BGTZ, 5 BLTZ, 6 BGEZ
jump_id  out  2  0 none, 1 J, 2 link (JAL/JALR)
jr_id  out  1  JR/JALR
alu_result_exe  out  32  combinational ALU output (forwarding)
dest_reg_num_exe  out  5  destination in EXE
reg_write_exe  out  1  EXE instruction writes a register
alu_result_mem  out  32  registered ALU result (address or value)
store_data_mem  out  32  registered rt value for stores
pc_mem  out  32  registered PC
dest_reg_num_mem  out  5  registered destination
jump_mem  out  2  registered jump code
ctrl_mem  out  7  {halted, reg_write, mem_to_reg, cache_en, is_sw_sb, is_lb_sb, mem_write}

Behaviour:
Decode:
- R-type (op 0), funct: ADD/ADDU 20/21, SUB/SUBU 22/23, AND 24, OR 25, XOR 26, NOR 27, SLT 2A, SLTU 2B, SLL 00, SRL 02, SRA 03, SLLV 04, SRLV 06, SRAV 07, JR 08, JALR 09, SYSCALL 0C (halt).
- R-type destination is rd.
- I-type, dest rt: ADDI/ADDIU 08/09, SLTI 0A, SLTIU 0B, ANDI 0C, ORI 0D, XORI 0E, LUI 0F.
- ANDI/ORI/XORI use the zero-extended immediate; all others sign-extend.
- Memory: LB 20, LW 23, SB 28, SW 2B.
  - val1 = rs, val2 = imm_ext, ALU op ADD.
  - cache_en = any load/store; mem_to_reg = load; mem_write = store; is_lb_sb = LB/SB; is_sw_sb = SW/SB.
- Branches: BEQ 04, BNE 05, BLEZ 06, BGTZ 07; REGIMM 01 with rt=0 is BLTZ, rt=1 is BGEZ.
  - zero is evaluated signed on rs_data/rt_data.
- J 02 (jump=1), JAL 03 (jump=2, dest 31).
- JALR: jr=1, jump=2, dest rd.
- Shifts:
  - SLL/SRL/SRA: val1 = shamt (inst[10:6]), val2 = rt.
  - Variable shifts: val1 = rs.
- SYSCALL: halted=1, no register write.
- Unknown opcode/funct: NOP (all control 0).
- reg_write is forced 0 when destination is register 0.
- reg_valid marks rs/rt as read; rt is read for R-type ALU ops, branches BEQ/BNE and stores.

ALU codes (4-bit):
- 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 NOR.
- 6 SLT (signed), 7 SLTU.
- 8 SLL (val2<<val1[4:0]), 9 SRL, 10 SRA.
- 11 LUI (val2<<16).
- 12–15 result 0.
- All arithmetic is 32-bit, wraps modulo 2^32; no overflow traps.

Pipeline:
- ID/EXE and EXE/MEM registers, both async-reset to 0. A reset state is a bubble: all outputs 0.
- Latency ID→EXE is one cycle; ID→MEM outputs is two cycles.
- freeze=1: both registers hold their contents; combinational outputs still track their inputs.
- Reset asserted mid-operation clears both registers immediately.

Test Plan:
- Reset then release, inst_id=0 (SLL $0) -> ctrl_mem=0, alu_result_mem=0, reg_write stays 0 (dest 0).
- ADDI $5,$0,-3 with rs_data=0 -> two cycles later alu_result_mem=FFFFFFFD, dest_reg_num_mem=5, ctrl_mem reg_write=1.
- SW $7,8($4), rs_data=100, rt_data=0xAB -> alu_result_mem=108, store_data_mem=0xAB, mem_write/cache_en/is_sw_sb=1, reg_write=0.
- BEQ with rs_data=rt_data=9 -> zero=1, branch_id=1 same cycle; BNE with equal values -> zero=0.
- SLT with rs=-1, rt=1 -> result 1; SLTU with the same operands -> 0; SRA 0x80000000 by 4 -> F8000000.
- freeze held 3 cycles during an LW stream -> MEM outputs unchanged; release -> advances one instruction per cycle.
- SYSCALL -> halted bit of ctrl_mem = 1 after two cycles.
